// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter with round-robin cyc-tenure grants
// and a watchdog that ends any transfer the slave never acknowledges.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_stall,
  output logic        m0_err,

  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_stall,
  output logic        m1_err,

  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  input  logic        s_stall,

  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [3:0]  outst_q, outst_d;

  logic own_cyc;
  logic own_stb;
  logic pending;
  logic accepted;
  logic timeout;

  // Owner's view of the bus; a transfer is pending while strobing or awaiting an ack.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (state_q)
      OWN0:    begin own_cyc = m0_cyc; own_stb = m0_stb; end
      OWN1:    begin own_cyc = m1_cyc; own_stb = m1_stb; end
      default: ;
    endcase
    pending  = own_stb || (outst_q != 4'd0);
    accepted = own_stb && !s_stall;
    timeout  = own_cyc && pending && !s_ack && (tcnt_q == TCNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      outst_q <= outst_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = '0;
    outst_d = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        // Timeout leaves last pointing at the offender, so the other master wins next.
        if (!own_cyc || timeout) begin
          state_d = IDLE;
        end else begin
          if (s_ack)        tcnt_d = '0;
          else if (pending) tcnt_d = tcnt_q + 16'd1;
          else              tcnt_d = tcnt_q;

          outst_d = outst_q;
          if (accepted && !s_ack && (outst_q != 4'hF))
            outst_d = outst_q + 4'd1;
          else if (!accepted && s_ack && (outst_q != 4'd0))
            outst_d = outst_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_sel    = '0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_rdata = '0;
    m0_ack   = 1'b0;
    m0_stall = 1'b1;
    m0_err   = 1'b0;
    m1_rdata = '0;
    m1_ack   = 1'b0;
    m1_stall = 1'b1;
    m1_err   = 1'b0;
    unique case (state_q)
      OWN0: begin
        s_cyc    = m0_cyc && !timeout;
        s_stb    = m0_stb && !timeout;
        s_we     = m0_we;
        s_sel    = m0_sel;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_rdata = s_rdata;
        m0_ack   = s_ack;
        m0_stall = s_stall;
        m0_err   = timeout;
      end
      OWN1: begin
        s_cyc    = m1_cyc && !timeout;
        s_stb    = m1_stb && !timeout;
        s_we     = m1_we;
        s_sel    = m1_sel;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_rdata = s_rdata;
        m1_ack   = s_ack;
        m1_stall = s_stall;
        m1_err   = timeout;
      end
      default: ;
    endcase
  end

  assign gnt = {state_q == OWN1, state_q == OWN0};

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (TIMEOUT = 8).
module tb_wb_master_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack, m0_stall, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack, m1_stall, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ack, s_stall;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_stall(m0_stall), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_stall(m1_stall), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_ack(s_ack), .s_stall(s_stall),
    .gnt(gnt)
  );

  // Inputs for a cycle are driven 1 time unit after its rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_addr = '0; m0_wdata = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_ack = 0; s_stall = 0;
  endtask

  task automatic apply_reset();
    next_cycle();
    clear_inputs();
    rst = 0;
    next_cycle();
    next_cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #12;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: gnt=%b expected 00", gnt); end
    checks++; if (s_cyc !== 0 || s_stb !== 0 || s_addr !== 0) begin errors++; $display("FAIL reset_s: cyc=%b stb=%b addr=%h expected 0", s_cyc, s_stb, s_addr); end
    checks++; if (m0_stall !== 1 || m1_stall !== 1) begin errors++; $display("FAIL reset_stall: m0=%b m1=%b expected 1 1", m0_stall, m1_stall); end
    checks++; if (m0_ack !== 0 || m0_err !== 0 || m1_ack !== 0 || m1_err !== 0) begin errors++; $display("FAIL reset_term: acks=%b%b errs=%b%b expected 0", m0_ack, m1_ack, m0_err, m1_err); end
    checks++; if (m0_rdata !== 0 || m1_rdata !== 0) begin errors++; $display("FAIL reset_rdata: m0=%h m1=%h expected 0", m0_rdata, m1_rdata); end
    @(posedge clk);
    #3 rst = 1;
  endtask

  task automatic test_single_write();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 32'h0000_0010; m0_wdata = 32'hCAFE_0001;
    #1;
    checks++; if (gnt !== 2'b00 || m0_stall !== 1) begin errors++; $display("FAIL sw_req: gnt=%b stall=%b expected 00 1", gnt, m0_stall); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL sw_gnt: gnt=%b expected 01", gnt); end
    checks++; if (s_cyc !== 1 || s_stb !== 1 || s_we !== 1 || s_addr !== 32'h10 || s_wdata !== 32'hCAFE_0001)
      begin errors++; $display("FAIL sw_bus: cyc=%b stb=%b we=%b addr=%h wdata=%h expected 1 1 1 00000010 cafe0001", s_cyc, s_stb, s_we, s_addr, s_wdata); end
    checks++; if (m0_ack !== 0 || m1_ack !== 0) begin errors++; $display("FAIL sw_noack: m0=%b m1=%b expected 0 0", m0_ack, m1_ack); end
    next_cycle();
    m0_stb = 0; s_ack = 1;
    #1;
    checks++; if (m0_ack !== 1 || m1_ack !== 0) begin errors++; $display("FAIL sw_ack: m0=%b m1=%b expected 1 0", m0_ack, m1_ack); end
    next_cycle();
    s_ack = 0; m0_cyc = 0; m0_we = 0;
    #1;
    checks++; if (s_cyc !== 0 || m0_ack !== 0 || m1_ack !== 0) begin errors++; $display("FAIL sw_drop: s_cyc=%b m0_ack=%b m1_ack=%b expected 0 0 0", s_cyc, m0_ack, m1_ack); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL sw_idle: gnt=%b expected 00", gnt); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      next_cycle();
      m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100 + r;
      m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200 + r;
      #1;
      checks++; if (gnt !== 2'b00 || m0_stall !== 1 || m1_stall !== 1) begin errors++; $display("FAIL rr%0d_req: gnt=%b stalls=%b%b expected 00 11", r, gnt, m0_stall, m1_stall); end
      next_cycle();
      #1;
      checks++; if (gnt !== 2'b01 || s_addr !== 32'h100 + r || m1_stall !== 1) begin errors++; $display("FAIL rr%0d_gnt0: gnt=%b addr=%h m1_stall=%b expected 01 %h 1", r, gnt, s_addr, m1_stall, 32'h100 + r); end
      next_cycle();
      m0_stb = 0; s_ack = 1; s_rdata = 32'h1111_0000 + r;
      #1;
      checks++; if (m0_ack !== 1 || m0_rdata !== 32'h1111_0000 + r || m1_ack !== 0 || m1_rdata !== 0)
        begin errors++; $display("FAIL rr%0d_rd0: ack=%b rdata=%h m1_ack=%b m1_rdata=%h", r, m0_ack, m0_rdata, m1_ack, m1_rdata); end
      next_cycle();
      s_ack = 0; m0_cyc = 0;
      #1;
      checks++; if (s_cyc !== 0 || gnt !== 2'b01) begin errors++; $display("FAIL rr%0d_rel: s_cyc=%b gnt=%b expected 0 01", r, s_cyc, gnt); end
      next_cycle();
      #1;
      checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rr%0d_gap: gnt=%b expected 00", r, gnt); end
      next_cycle();
      #1;
      checks++; if (gnt !== 2'b10 || s_addr !== 32'h200 + r) begin errors++; $display("FAIL rr%0d_gnt1: gnt=%b addr=%h expected 10 %h", r, gnt, s_addr, 32'h200 + r); end
      next_cycle();
      m1_stb = 0; s_ack = 1; s_rdata = 32'h2222_0000 + r;
      #1;
      checks++; if (m1_ack !== 1 || m1_rdata !== 32'h2222_0000 + r || m0_ack !== 0) begin errors++; $display("FAIL rr%0d_rd1: ack=%b rdata=%h m0_ack=%b", r, m1_ack, m1_rdata, m0_ack); end
      next_cycle();
      s_ack = 0; m1_cyc = 0;
    end
  endtask

  task automatic test_hold_off();
    next_cycle();
    m0_cyc = 1; m0_stb = 0;
    for (int i = 0; i <= 4; i++) begin
      next_cycle();
      m0_stb = (i < 4); m0_addr = 32'h300 + 4 * i;
      s_ack = (i > 0); s_rdata = 32'hB0B0_0000 + i;
      if (i == 1) begin m1_cyc = 1; m1_stb = 1; m1_addr = 32'h400; end
      #1;
      checks++; if (gnt !== 2'b01 || m1_stall !== 1) begin errors++; $display("FAIL ho_burst%0d: gnt=%b m1_stall=%b expected 01 1", i, gnt, m1_stall); end
      if (i > 0) begin
        checks++; if (m0_ack !== 1 || m0_rdata !== 32'hB0B0_0000 + i) begin errors++; $display("FAIL ho_data%0d: ack=%b rdata=%h expected 1 %h", i, m0_ack, m0_rdata, 32'hB0B0_0000 + i); end
      end
    end
    next_cycle();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    checks++; if (m1_stall !== 1 || s_cyc !== 0) begin errors++; $display("FAIL ho_rel: m1_stall=%b s_cyc=%b expected 1 0", m1_stall, s_cyc); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b00 || m1_stall !== 1) begin errors++; $display("FAIL ho_gap: gnt=%b m1_stall=%b expected 00 1", gnt, m1_stall); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b10 || m1_stall !== 0 || s_addr !== 32'h400) begin errors++; $display("FAIL ho_gnt1: gnt=%b stall=%b addr=%h expected 10 0 00000400", gnt, m1_stall, s_addr); end
    next_cycle();
    m1_stb = 0; s_ack = 1;
    #1;
    checks++; if (m1_ack !== 1) begin errors++; $display("FAIL ho_ack1: m1_ack=%b expected 1", m1_ack); end
    next_cycle();
    s_ack = 0; m1_cyc = 0;
  endtask

  task automatic test_watchdog();
    next_cycle();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h500;
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b10 || m1_err !== 0) begin errors++; $display("FAIL wd_gnt: gnt=%b err=%b expected 10 0", gnt, m1_err); end
    for (int k = 1; k < TO; k++) begin
      next_cycle();
      m1_stb = 0;
      if (k == 3) begin m0_cyc = 1; m0_stb = 1; m0_addr = 32'h600; end
      #1;
      if (k < TO - 1) begin
        checks++; if (m1_err !== 0 || s_cyc !== 1) begin errors++; $display("FAIL wd_wait%0d: err=%b s_cyc=%b expected 0 1", k, m1_err, s_cyc); end
      end else begin
        checks++; if (m1_err !== 1 || s_cyc !== 0 || m1_ack !== 0 || m0_err !== 0)
          begin errors++; $display("FAIL wd_err: m1_err=%b s_cyc=%b m1_ack=%b m0_err=%b expected 1 0 0 0", m1_err, s_cyc, m1_ack, m0_err); end
      end
    end
    next_cycle();
    m1_stb = 1;
    #1;
    checks++; if (gnt !== 2'b00 || m1_err !== 0) begin errors++; $display("FAIL wd_idle: gnt=%b err=%b expected 00 0", gnt, m1_err); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b01 || s_addr !== 32'h600) begin errors++; $display("FAIL wd_next: gnt=%b addr=%h expected 01 00000600", gnt, s_addr); end
  endtask

  task automatic test_ack_collision();
    apply_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h700;
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ac_gnt: gnt=%b expected 01", gnt); end
    for (int k = 1; k < TO; k++) begin
      next_cycle();
      m0_stb = 0; s_ack = (k == TO - 1); s_rdata = 32'h5A5A_5A5A;
    end
    #1;
    checks++; if (m0_ack !== 1 || m0_err !== 0 || s_cyc !== 1 || m0_rdata !== 32'h5A5A_5A5A)
      begin errors++; $display("FAIL ac_hit: ack=%b err=%b s_cyc=%b rdata=%h expected 1 0 1 5a5a5a5a", m0_ack, m0_err, s_cyc, m0_rdata); end
    next_cycle();
    s_ack = 0;
    #1;
    checks++; if (gnt !== 2'b01 || m0_err !== 0) begin errors++; $display("FAIL ac_stay: gnt=%b err=%b expected 01 0", gnt, m0_err); end
    next_cycle();
    m0_cyc = 0;
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h800;
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rm_gnt: gnt=%b expected 10", gnt); end
    next_cycle();
    m1_stb = 0; s_ack = 1;
    #3 rst = 0;
    #1;
    checks++; if (s_cyc !== 0 || gnt !== 2'b00 || m1_ack !== 0 || m1_err !== 0)
      begin errors++; $display("FAIL rm_async: s_cyc=%b gnt=%b ack=%b err=%b expected 0 00 0 0", s_cyc, gnt, m1_ack, m1_err); end
    s_ack = 0;
    next_cycle();
    #2 rst = 1;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h900; m1_stb = 1;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rm_idle: gnt=%b expected 00", gnt); end
    next_cycle();
    #1;
    checks++; if (gnt !== 2'b01 || s_addr !== 32'h900) begin errors++; $display("FAIL rm_first: gnt=%b addr=%h expected 01 00000900", gnt, s_addr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold_off();
    test_watchdog();
    test_ack_collision();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
